// File: rtl/alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_sequencer
// Brief    : Collects A then B(+opcode) serially, lets an external ALU settle
//            for one cycle, registers the result and holds it until consumed.
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_sequencer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic [1:0]   op_in,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic [1:0]   OP,
  input  logic [N-1:0] alu_result,
  output logic [N-1:0] res,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         busy,
  output logic [7:0]   op_count
);

  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    EXEC  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [1:0]   op_q, op_d;
  logic [N-1:0] res_q, res_d;
  logic         res_valid_q, res_valid_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         armed_q, armed_d;
  logic         din_accept;

  // armed_q keeps din_ready low until the first clock edge after reset release.
  assign armed_d    = 1'b1;
  assign din_ready  = armed_q && ((state_q == GET_A) || (state_q == GET_B));
  assign din_accept = din_valid && din_ready;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    cnt_d       = cnt_q;
    case (state_q)
      GET_A: begin
        if (din_accept) begin
          a_d     = din;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (din_accept) begin
          b_d     = din;
          op_d    = op_in;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d       = alu_result;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          cnt_d       = cnt_q + 8'd1;
          state_d     = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= GET_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 2'b00;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      cnt_q       <= 8'd0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign OP        = op_q;
  assign res       = res_q;
  assign res_valid = res_valid_q;
  assign op_count  = cnt_q;
  assign busy      = (state_q != GET_A);

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_sequencer
// Brief    : Scoreboard bench: stimulus pushes expected results, a negedge
//            monitor pops and compares on every res handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_sequencer;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic [1:0]   op_in = 2'b00;
  logic [N-1:0] A, B;
  logic [1:0]   OP;
  logic [N-1:0] alu_result;
  logic [N-1:0] res;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic         busy;
  logic [7:0]   op_count;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [7:0]   exp_cnt = 8'd0;
  logic [N-1:0] sb[$];
  logic [N-1:0] mon_exp;

  alu_operand_sequencer #(.N(N)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .op_in(op_in), .A(A), .B(B), .OP(OP), .alu_result(alu_result), .res(res),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] alu_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a | b;
      2'b10:   return a - b;
      default: return a ^ b;
    endcase
  endfunction

  // Downstream combinational ALU
  assign alu_result = alu_model(A, B, OP);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_exp = sb.pop_front();
        check("sb_res", {28'd0, res}, {28'd0, mon_exp});
      end
    end
  end

  task automatic send_word(input logic [N-1:0] w, input logic [1:0] op);
    int t = 0;
    din       = w;
    op_in     = op;
    din_valid = 1'b1;
    while (!din_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 20) check("din_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op,
                        input logic [N-1:0] exp, input int hold);
    res_ready = (hold == 0);
    sb.push_back(exp);
    send_word(a, 2'b00);
    check("busy_get_b", {31'd0, busy}, 32'd1);
    send_word(b, op);
    check("cap_A", {28'd0, A}, {28'd0, a});
    check("cap_B", {28'd0, B}, {28'd0, b});
    check("cap_OP", {30'd0, OP}, {30'd0, op});
    check("exec_res_valid", {31'd0, res_valid}, 32'd0);
    check("exec_din_ready", {31'd0, din_ready}, 32'd0);
    @(posedge clk); #1;
    check("latency_res_valid", {31'd0, res_valid}, 32'd1);
    check("res_direct", {28'd0, res}, {28'd0, exp});
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        din       = ~a;
        din_valid = 1'b1;
      end
      @(posedge clk); #1;
      din_valid = 1'b0;
      check("hold_res", {28'd0, res}, {28'd0, exp});
      check("hold_res_valid", {31'd0, res_valid}, 32'd1);
      check("hold_din_ready", {31'd0, din_ready}, 32'd0);
      check("hold_A_unchanged", {28'd0, A}, {28'd0, a});
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 8'd1;
    check("done_res_valid", {31'd0, res_valid}, 32'd0);
    check("done_op_count", {24'd0, op_count}, {24'd0, exp_cnt});
    check("done_din_ready", {31'd0, din_ready}, 32'd1);
    check("done_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] ra, rb;
    logic [1:0]   rop;
    #2 rst = 1'b1;
    #4;
    check("rst_A", {28'd0, A}, 32'd0);
    check("rst_B", {28'd0, B}, 32'd0);
    check("rst_OP", {30'd0, OP}, 32'd0);
    check("rst_res", {28'd0, res}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_op_count", {24'd0, op_count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_din_ready", {31'd0, din_ready}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_din_ready", {31'd0, din_ready}, 32'd1);

    run_op(4'd3, 4'd5, 2'b00, 4'd8, 0);        // add
    run_op(4'd2, 4'd7, 2'b10, 4'b1011, 1);     // sub wrap
    run_op(4'd15, 4'd1, 2'b00, 4'b0000, 0);    // add overflow
    run_op(4'd5, 4'd10, 2'b01, 4'd15, 2);      // or
    run_op(4'd12, 4'd10, 2'b11, 4'd6, 5);      // xor with backpressure

    // Abort in GET_B after A has been captured
    res_ready = 1'b0;
    send_word(4'd9, 2'b00);
    check("pre_abort_A", {28'd0, A}, 32'd9);
    #2 rst = 1'b1;
    #1;
    check("abort_A", {28'd0, A}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_op_count", {24'd0, op_count}, 32'd0);
    check("abort_din_ready", {31'd0, din_ready}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    exp_cnt = 8'd0;
    check("abort_rel_din_ready", {31'd0, din_ready}, 32'd1);
    check("abort_rel_A", {28'd0, A}, 32'd0);
    check("abort_rel_res_valid", {31'd0, res_valid}, 32'd0);

    for (int k = 0; k < 256; k++) begin
      ra  = N'($urandom_range(0, 15));
      rb  = N'($urandom_range(0, 15));
      rop = 2'($urandom_range(0, 3));
      run_op(ra, rb, rop, alu_model(ra, rb, rop), 0);
      if (k == 254) check("count_255", {24'd0, op_count}, 32'd255);
    end
    check("count_wrap", {24'd0, op_count}, 32'd0);

    repeat (2) @(posedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
